// File: rtl/avalon_onchip_ram_pipe.sv
//============================================================================
// Module  : avalon_onchip_ram_pipe
// Purpose : Avalon-MM single-port on-chip RAM slave with pipelined reads
//           (readdatavalid), waitrequest flow control, an optional
//           post-reset zero-clear pass and out-of-range address handling.
// Ports   : clk, reset_n (sync, active-low)
//           address/byteenable/chipselect/read/write/writedata - Avalon cmd
//           clken     - clock enable, low freezes RAM, pipeline and FSM
//           reset_req - blocks new commands, in-flight reads still drain
//           waitrequest/readdata/readdatavalid - Avalon response
//           init_busy - clear pass in progress
//           parity_err - sticky lane parity error (ONCHIP_RAM_PARITY_EN only)
// Option  : define ONCHIP_RAM_PARITY_EN to store one even-parity bit per
//           byte lane and check it on every returned read beat.
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module avalon_onchip_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 8192,
  parameter int ADDR_W         = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0,
  parameter     INIT_FILE      = "onchip_mem.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                init_busy
`ifdef ONCHIP_RAM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NB = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
  // Parity bits live above the data bits in the same RAM word.
  localparam int RW = DATA_W + NB;
`else
  localparam int RW = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [RW-1:0]       mem [DEPTH];
  logic [RW-1:0]       ram_word;
  logic                run;
  logic                in_range;
  logic                accept;
  logic                acc_wr;
  logic                acc_rd;
  logic                out_valid;
  logic [RW-1:0]       out_word;

  // The init image is applied by the device memory-initialisation flow,
  // not by this RTL; the parameter is kept so integration scripts can pass
  // it through unchanged.
  logic unused_init_file;
  assign unused_init_file = ^INIT_FILE;

  assign run         = (state == ST_RUN);
  assign init_busy   = ~run;
  // reset_n is folded in so no command is seen as accepted while in reset.
  assign waitrequest = ~reset_n | ~run | ~clken | reset_req;

  assign in_range = ({1'b0, address} < DEPTH_LIM);
  assign accept   = chipselect & (read | write) & ~waitrequest;
  assign acc_wr   = accept & write;
  // A combined read+write is a write only.
  assign acc_rd   = accept & read & ~write;

  // Out-of-range reads return an all-zero word (parity 0 included).
  assign ram_word = in_range ? mem[address] : '0;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_addr <= '0;
    end else if (clken && state == ST_INIT) begin
      if (clr_addr == LAST_ADDR) begin
        state <= ST_RUN;
      end else begin
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RAM
  always_ff @(posedge clk) begin
    if (reset_n && clken) begin
      if (!run) begin
        mem[clr_addr] <= '0;
      end else if (acc_wr && in_range) begin
        for (int i = 0; i < NB; i++) begin
          if (byteenable[i]) begin
            mem[address][8*i +: 8] <= writedata[8*i +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            mem[address][DATA_W+i] <= ^writedata[8*i +: 8];
`endif
          end
        end
      end
    end
  end

  // ------------------------------------------------------- read pipeline
  // out_word only updates when a beat arrives, so readdata holds between
  // valids. Any latency other than 2 builds the single-stage pipeline.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic          p_valid;
      logic [RW-1:0] p_word;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          p_valid   <= 1'b0;
          p_word    <= '0;
          out_valid <= 1'b0;
          out_word  <= '0;
        end else if (clken) begin
          p_valid   <= acc_rd;
          if (acc_rd) p_word <= ram_word;
          out_valid <= p_valid;
          if (p_valid) out_word <= p_word;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          out_word  <= '0;
        end else if (clken) begin
          out_valid <= acc_rd;
          if (acc_rd) out_word <= ram_word;
        end
      end
    end
  endgenerate

  // A pending beat is held back while clken is low and shows once it rises.
  assign readdatavalid = out_valid & clken;
  assign readdata      = out_word[DATA_W-1:0];

`ifdef ONCHIP_RAM_PARITY_EN
  logic err_q;
  logic lane_err;

  always_comb begin
    lane_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      lane_err = lane_err | (out_word[DATA_W+i] != ^out_word[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (readdatavalid && lane_err) begin
      err_q <= 1'b1;
    end
  end

  // Visible in the same cycle as the offending readdatavalid, then sticky.
  assign parity_err = err_q | (readdatavalid & lane_err);
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_onchip_ram_pipe.sv
//============================================================================
// Module  : tb_avalon_onchip_ram_pipe
// Purpose : Directed self-checking bench. Two instances share one command
//           bus: dut_a = defaults with the zero-clear pass enabled
//           (8192 words, latency 1); dut_b = 6000 words, latency 2, no
//           clear. Each read is checked on both at their own latency.
// Rev     : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_avalon_onchip_ram_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;

  logic        a_wr, a_rv, a_busy;
  logic [31:0] a_rd;
  logic        b_wr, b_rv, b_busy;
  logic [31:0] b_rd;
`ifdef ONCHIP_RAM_PARITY_EN
  logic        a_perr, b_perr;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] vals [4];

  always #5 clk = ~clk;

  avalon_onchip_ram_pipe #(
    .DATA_W(32), .DEPTH(8192), .ADDR_W(13), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(a_wr), .readdata(a_rd),
    .readdatavalid(a_rv), .init_busy(a_busy)
`ifdef ONCHIP_RAM_PARITY_EN
    , .parity_err(a_perr)
`endif
  );

  avalon_onchip_ram_pipe #(
    .DATA_W(32), .DEPTH(6000), .ADDR_W(13), .READ_LATENCY(2), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .waitrequest(b_wr), .readdata(b_rd),
    .readdatavalid(b_rv), .init_busy(b_busy)
`ifdef ONCHIP_RAM_PARITY_EN
    , .parity_err(b_perr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic do_write(input logic [12:0] addr, input logic [31:0] d, input logic [3:0] be);
    address = addr; writedata = d; byteenable = be;
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic do_read(input logic [12:0] addr, input logic [31:0] ea, input logic [31:0] eb);
    address = addr; chipselect = 1'b1; read = 1'b1; write = 1'b0;
    #1;
    check("rd_wait_a", a_wr, 0);
    check("rd_wait_b", b_wr, 0);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check("rd_l1_valid_a", a_rv, 1);
    check("rd_l1_data_a", a_rd, ea);
    check("rd_l1_valid_b", b_rv, 0);
    @(negedge clk);
    check("rd_l2_valid_a", a_rv, 0);
    check("rd_l2_valid_b", b_rv, 1);
    check("rd_l2_data_b", b_rd, eb);
  endtask

  // Called on the falling edge where reset_n was just released.
  task automatic count_busy(input string tag, input int exp);
    int n = 0;
    int wr_low = 0;
    #1;
    while (a_busy === 1'b1 && n < 10000) begin
      if (a_wr !== 1'b1) wr_low++;
      n++;
      @(negedge clk);
    end
    check(tag, n, exp);
    check("init_waitrequest", wr_low, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;
    repeat (3) @(negedge clk);

    // ---------------- reset state
    check("rst_wait_a", a_wr, 1);
    check("rst_wait_b", b_wr, 1);
    check("rst_valid_a", a_rv, 0);
    check("rst_valid_b", b_rv, 0);
    check("rst_data_a", a_rd, 32'h0);
    check("rst_data_b", b_rd, 32'h0);
    check("rst_busy_a", a_busy, 1);
    check("rst_busy_b", b_busy, 0);
`ifdef ONCHIP_RAM_PARITY_EN
    check("rst_perr_a", a_perr, 0);
`endif

    // ---------------- clear pass: exactly DEPTH cycles
    reset_n = 1'b1;
    count_busy("init_len", 8192);
    check("run_busy_b", b_busy, 0);
    do_read(13'h1FFF, 32'h0, 32'h0);   // a: cleared word, b: out of range

    // ---------------- byte enables, write-then-read, byteenable=0 no-op
    do_write(13'h10, 32'h11223344, 4'hF);
    do_write(13'h10, 32'hDEADBEEF, 4'b0101);
    do_read(13'h10, 32'h11AD33EF, 32'h11AD33EF);
    do_write(13'h10, 32'hFFFFFFFF, 4'b0000);
    do_read(13'h10, 32'h11AD33EF, 32'h11AD33EF);

    // ---------------- back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA5000000 + 32'(i * 17);
      do_write(13'(i), vals[i], 4'hF);
    end
    address = 13'd0; chipselect = 1'b1; read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 4) address = 13'(k);
      else begin chipselect = 1'b0; read = 1'b0; end
      check("b2b_valid_a", a_rv, 32'(k <= 4));
      if (k <= 4) check("b2b_data_a", a_rd, vals[k-1]);
      check("b2b_valid_b", b_rv, 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("b2b_data_b", b_rd, vals[k-2]);
    end

    // ---------------- read+write together acts as a write only
    address = 13'h20; writedata = 32'h55; byteenable = 4'hF;
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("rw_novalid_a", a_rv, 0);
      check("rw_novalid_b", b_rv, 0);
      @(negedge clk);
    end
    do_read(13'h20, 32'h55, 32'h55);

    // ---------------- clken stall with a read in flight
    address = 13'd1; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    clken = 1'b0; read = 1'b0; write = 1'b1; writedata = 32'h0BAD0BAD;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("stall_valid_a", a_rv, 0);
      check("stall_valid_b", b_rv, 0);
      check("stall_wait_a", a_wr, 1);
      check("stall_wait_b", b_wr, 1);
      @(negedge clk);
    end
    chipselect = 1'b0; write = 1'b0; clken = 1'b1;
    #1;
    check("unstall_valid_a", a_rv, 1);
    check("unstall_data_a", a_rd, vals[1]);
    check("unstall_valid_b", b_rv, 0);
    @(negedge clk);
    check("unstall_late_a", a_rv, 0);
    check("unstall_valid_b2", b_rv, 1);
    check("unstall_data_b", b_rd, vals[1]);
    do_read(13'd1, vals[1], vals[1]);

    // ---------------- reset_req blocks new commands, drains in-flight
    reset_req = 1'b1; address = 13'd2; chipselect = 1'b1; read = 1'b1;
    #1;
    check("rreq_wait_a", a_wr, 1);
    check("rreq_wait_b", b_wr, 1);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; reset_req = 1'b0;
    check("rreq_novalid_a", a_rv, 0);
    @(negedge clk);
    check("rreq_novalid_b", b_rv, 0);
    address = 13'd3; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; reset_req = 1'b1;
    check("drain_valid_a", a_rv, 1);
    check("drain_data_a", a_rd, vals[3]);
    @(negedge clk);
    check("drain_valid_b", b_rv, 1);
    check("drain_data_b", b_rd, vals[3]);
    reset_req = 1'b0;

    // ---------------- out-of-range handling on the 6000-word instance
    do_write(13'd6000, 32'h12345678, 4'hF);
    do_read(13'd6000, 32'h12345678, 32'h0);
    do_write(13'd5999, 32'hCAFEF00D, 4'hF);
    do_read(13'd5999, 32'hCAFEF00D, 32'hCAFEF00D);

`ifdef ONCHIP_RAM_PARITY_EN
    // ---------------- parity: corrupt one stored data bit at address 5
    do_write(13'd5, 32'h0000000F, 4'hF);
    check("perr_pre_a", a_perr, 0);
    check("perr_pre_b", b_perr, 0);
    dut_a.mem[5][0] = ~dut_a.mem[5][0];
    dut_b.mem[5][0] = ~dut_b.mem[5][0];
    address = 13'd5; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check("perr_valid_a", a_rv, 1);
    check("perr_data_a", a_rd, 32'h0000000E);
    check("perr_set_a", a_perr, 1);
    @(negedge clk);
    check("perr_valid_b", b_rv, 1);
    check("perr_set_b", b_perr, 1);
    repeat (3) @(negedge clk);
    check("perr_sticky_a", a_perr, 1);
    check("perr_sticky_b", b_perr, 1);
`endif

    // ---------------- reset mid-read: in-flight beat on b is lost
    address = 13'd2; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rstmid_valid_b", b_rv, 0);
    check("rstmid_data_b", b_rd, 32'h0);
`ifdef ONCHIP_RAM_PARITY_EN
    check("rst_perr_clr_a", a_perr, 0);
    check("rst_perr_clr_b", b_perr, 0);
`endif
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("rstmid_late_b", b_rv, 0);
    end

    // b keeps its contents across reset while a is clearing
    address = 13'h10; chipselect = 1'b1; read = 1'b1;
    #1;
    check("keep_wait_b", b_wr, 0);
    check("keep_wait_a", a_wr, 1);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check("keep_novalid_a", a_rv, 0);
    @(negedge clk);
    check("keep_valid_b", b_rv, 1);
    check("keep_data_b", b_rd, 32'h11AD33EF);

    // ---------------- reset mid-INIT restarts the clear at word 0
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    count_busy("reinit_len", 8192);
    do_read(13'h10, 32'h0, 32'h11AD33EF);
    do_read(13'd5999, 32'h0, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
